// File: rtl/stackcalc_display_seq_pkg.sv
// Shared definitions for the stack-calculator result display sequencer:
// FSM state encoding and the hex-digit seven-segment pattern table.
package stackcalc_display_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Active-high segment patterns, bit0 = a ... bit6 = g, for digits 0..F.
  localparam logic [6:0] HEX7SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/stackcalc_hex7seg.sv
// Combinational hex digit to seven-segment decoder.
module stackcalc_hex7seg
  import stackcalc_display_seq_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segments
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    o_segments = HEX7SEG_LUT[i_nibble];
  end

endmodule

// File: rtl/stackcalc_display_seq.sv
// Shows each accepted result byte as high nibble (with dp), low nibble,
// then a blank gap, each phase MAX_COUNT cycles long. A one-entry pending
// slot lets the next result be accepted while the current one is shown.
module stackcalc_display_seq
  import stackcalc_display_seq_pkg::*;
#(
  parameter int MAX_COUNT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] segments,
  output logic       dp,
  output logic       busy
);

  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_disp;
  logic [7:0]    r_pend;
  logic          r_pend_full;

  logic          w_hs;
  logic          w_cnt_last;
  logic          w_load_pend;
  logic          w_load_in;
  logic          w_fill_pend;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg;

  assign in_ready   = (r_state == ST_IDLE) || !r_pend_full;
  assign w_hs       = in_valid && in_ready;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // The pending byte moves to the display when idle or when a gap expires.
  assign w_load_pend = r_pend_full &&
                       ((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_cnt_last));
  // A fresh byte goes straight to the display only from an empty idle.
  assign w_load_in   = (r_state == ST_IDLE) && !r_pend_full && w_hs;
  // Every other handshake parks the byte in the pending slot.
  assign w_fill_pend = w_hs && !w_load_in;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision; the gap exit looks at pending as registered now.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_full || w_hs) w_state_nxt = ST_HI;
        else                     w_state_nxt = ST_IDLE;
      end
      ST_HI: begin
        if (w_cnt_last) w_state_nxt = ST_LO;
        else            w_state_nxt = ST_HI;
      end
      ST_LO: begin
        if (w_cnt_last) w_state_nxt = ST_GAP;
        else            w_state_nxt = ST_LO;
      end
      ST_GAP: begin
        if (!w_cnt_last)      w_state_nxt = ST_GAP;
        else if (r_pend_full) w_state_nxt = ST_HI;
        else                  w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the registered state and display byte.
  always_comb begin
    segments = 7'h00;
    dp       = 1'b0;
    busy     = (r_state != ST_IDLE);
    w_nibble = (r_state == ST_HI) ? r_disp[7:4] : r_disp[3:0];
    case (r_state)
      ST_HI: begin
        segments = w_seg;
        dp       = 1'b1;
      end
      ST_LO: begin
        segments = w_seg;
        dp       = 1'b0;
      end
      default: begin
        segments = 7'h00;
        dp       = 1'b0;
      end
    endcase
  end

  // Dwell counter: restarts on every state entry, held at 0 while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CW{1'b0}};
    end else if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Display register and pending slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp      <= 8'h00;
      r_pend      <= 8'h00;
      r_pend_full <= 1'b0;
    end else begin
      if (w_load_pend) begin
        r_disp <= r_pend;
      end else if (w_load_in) begin
        r_disp <= in_data;
      end
      if (w_fill_pend) begin
        r_pend      <= in_data;
        r_pend_full <= 1'b1;
      end else if (w_load_pend) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  stackcalc_hex7seg u_hex7seg (
    .i_nibble   (w_nibble),
    .o_segments (w_seg)
  );

endmodule

// File: tb/tb_stackcalc_display_seq.sv
// Self-checking bench for stackcalc_display_seq with MAX_COUNT = 4.
module tb_stackcalc_display_seq;

  localparam int MC = 4;
  localparam logic [6:0] HEX_REF [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] segments;
  logic       dp;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stackcalc_display_seq #(.MAX_COUNT(MC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .segments (segments),
    .dp       (dp),
    .busy     (busy)
  );

  // Reference model: one shown byte occupies a frame of 3*MC cycles,
  // m_pos is the position inside that frame.
  bit         m_active;
  int         m_pos;
  logic [7:0] m_disp;
  logic [7:0] m_pend;
  bit         m_pend_full;

  function automatic bit m_ready();
    return !m_active || !m_pend_full;
  endfunction

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_disp = 8'h00; m_pend = 8'h00; m_pend_full = 0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d);
    bit hs;
    hs = v && m_ready();
    if (!m_active) begin
      if (m_pend_full) begin
        m_disp = m_pend; m_pend_full = hs; if (hs) m_pend = d;
        m_active = 1; m_pos = 0;
      end else if (hs) begin
        m_disp = d; m_active = 1; m_pos = 0;
      end
    end else if (m_pos == 3*MC-1) begin
      if (m_pend_full) begin
        m_disp = m_pend; m_pend_full = 0; m_pos = 0;
      end else begin
        m_active = 0; m_pos = 0;
        if (hs) begin m_pend = d; m_pend_full = 1; end
      end
    end else begin
      m_pos++;
      if (hs) begin m_pend = d; m_pend_full = 1; end
    end
  endtask

  function automatic logic [6:0] exp_seg();
    if (!m_active) return 7'h00;
    case (m_pos / MC)
      0:       return HEX_REF[m_disp[7:4]];
      1:       return HEX_REF[m_disp[3:0]];
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".seg"},   32'(segments), 32'(exp_seg()));
    chk({tag, ".dp"},    32'(dp),       32'(m_active && (m_pos / MC == 0)));
    chk({tag, ".busy"},  32'(busy),     32'(m_active));
    chk({tag, ".ready"}, 32'(in_ready), 32'(m_ready()));
  endtask

  // Drive inputs for one cycle, advance model on the edge, check at negedge.
  task automatic step(input bit v, input logic [7:0] d, input string tag);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while ((m_active || m_pend_full) && i < 100) begin
      step(1'b0, 8'h00, tag);
      i++;
    end
    if (m_active || m_pend_full) begin
      n_checks++; n_errors++;
      $display("FAIL %s: timeout waiting for idle", tag);
    end
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic [6:0] seg;
    bit         dp;
    bit         busy;
    bit         rdy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Single-byte 0x3A display timeline, one row per clock edge.
    tbl[0] = '{1'b1, 8'h3A, 7'h4F, 1'b1, 1'b1, 1'b1};
    for (int i = 1; i < 4; i++)  tbl[i] = '{1'b0, 8'h00, 7'h4F, 1'b1, 1'b1, 1'b1};
    for (int i = 4; i < 8; i++)  tbl[i] = '{1'b0, 8'h00, 7'h77, 1'b0, 1'b1, 1'b1};
    for (int i = 8; i < 12; i++) tbl[i] = '{1'b0, 8'h00, 7'h00, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 7'h00, 1'b0, 1'b0, 1'b1};

    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    model_reset();
    #1;
    chk("reset.seg", 32'(segments), 32'h00);
    chk("reset.dp", 32'(dp), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.ready", 32'(in_ready), 32'h1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Table: first handshake on the first edge after reset release.
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d;
      @(posedge clk);
      model_edge(tbl[i].v, tbl[i].d);
      @(negedge clk);
      chk($sformatf("tbl%0d.seg", i), 32'(segments), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d.dp", i), 32'(dp), 32'(tbl[i].dp));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d.ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      check_model("tblm");
    end

    // Back-to-back: 0x9F queued during HI of 0x12.
    step(1'b1, 8'h12, "b2b");
    step(1'b0, 8'h00, "b2b"); step(1'b0, 8'h00, "b2b");
    chk("b2b.ready_before", 32'(in_ready), 32'h1);
    step(1'b1, 8'h9F, "b2b");
    chk("b2b.ready_after", 32'(in_ready), 32'h0);
    for (int i = 4; i < 12; i++) begin
      step(1'b0, 8'h00, "b2b");
      chk("b2b.busy_held", 32'(busy), 32'h1);
    end
    step(1'b0, 8'h00, "b2b");
    chk("b2b.hi_seg", 32'(segments), 32'h6F);
    chk("b2b.hi_dp", 32'(dp), 32'h1);
    chk("b2b.hi_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, "b2b");
    chk("b2b.lo_seg", 32'(segments), 32'h71);
    wait_idle("b2b");

    // Third value held valid while pending is full.
    step(1'b1, 8'h11, "hold");
    step(1'b1, 8'h22, "hold");
    for (int i = 2; i < 12; i++) begin
      step(1'b1, 8'h33, "hold");
      chk("hold.ready_low", 32'(in_ready), 32'h0);
    end
    step(1'b1, 8'h33, "hold");
    chk("hold.drained_seg", 32'(segments), 32'h5B);
    chk("hold.ready_free", 32'(in_ready), 32'h1);
    step(1'b1, 8'h33, "hold");
    chk("hold.ready_refull", 32'(in_ready), 32'h0);
    wait_idle("hold");

    // Handshake in the last GAP cycle with pending empty.
    step(1'b1, 8'h21, "lastgap");
    for (int i = 1; i < 12; i++) step(1'b0, 8'h00, "lastgap");
    step(1'b1, 8'h84, "lastgap");
    chk("lastgap.idle_busy", 32'(busy), 32'h0);
    chk("lastgap.idle_seg", 32'(segments), 32'h00);
    step(1'b0, 8'h00, "lastgap");
    chk("lastgap.hi_seg", 32'(segments), 32'h7F);
    chk("lastgap.hi_dp", 32'(dp), 32'h1);
    wait_idle("lastgap");

    // Asynchronous reset during LO of 0xC5 with 0x44 pending.
    step(1'b1, 8'hC5, "arst");
    step(1'b1, 8'h44, "arst");
    for (int i = 2; i < 6; i++) step(1'b0, 8'h00, "arst");
    chk("arst.in_lo", 32'(segments), 32'h6D);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.seg", 32'(segments), 32'h00);
    chk("arst.dp", 32'(dp), 32'h0);
    chk("arst.busy", 32'(busy), 32'h0);
    chk("arst.ready", 32'(in_ready), 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, "arst_post");

    // Nibble sweep through HI and LO.
    for (int n = 0; n < 16; n++) begin
      logic [3:0] hi_n;
      logic [3:0] lo_n;
      hi_n = 4'(n);
      lo_n = 4'(15 - n);
      step(1'b1, {hi_n, lo_n}, "sweep");
      chk($sformatf("sweep%0d.hi", n), 32'(segments), 32'(HEX_REF[n]));
      for (int i = 0; i < MC; i++) step(1'b0, 8'h00, "sweep");
      chk($sformatf("sweep%0d.lo", n), 32'(segments), 32'(HEX_REF[15-n]));
      wait_idle("sweep");
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom), "rand");
    end
    wait_idle("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stackcalc_display_seq.md
STACKCALC_DISPLAY_SEQ -- requirements
Module: stackcalc_display_seq

Interface
REQ-001 Parameter MAX_COUNT, default 100, dwell length in clk cycles of each display phase; legal range >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  8  result byte from the stack calculator.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept in_data this cycle.
REQ-007 segments  output  7  active-high seven-segment pattern, bit0=a ... bit6=g.
REQ-008 dp  output  1  high while the high nibble is displayed.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 Handshake SHALL occur on a rising edge where in_valid and in_ready are both 1; in_data is captured on that edge.
REQ-011 FSM states SHALL be IDLE, HI, LO, GAP.
REQ-012 IDLE: segments=0x00, dp=0; a handshake SHALL load the display register and enter HI on the same edge.
REQ-013 IDLE with the pending slot full SHALL move pending into the display register, clear pending, and enter HI on the next edge.
REQ-014 HI SHALL show hex(display[7:4]) with dp=1; LO SHALL show hex(display[3:0]) with dp=0; GAP SHALL show 0x00 with dp=0.
REQ-015 Each of HI, LO, GAP SHALL last exactly MAX_COUNT cycles, timed by a dwell counter cleared to 0 on state entry and advancing by 1 per cycle.
REQ-016 Transitions: HI->LO and LO->GAP when counter==MAX_COUNT-1; GAP->HI when the counter expires and pending is full (pending loaded, slot cleared); GAP->IDLE when the counter expires and pending is empty.
REQ-017 A one-entry pending slot SHALL accept handshakes while busy; in_ready = (state==IDLE) or pending empty.
REQ-018 A handshake in the final GAP cycle with pending empty SHALL fill pending; the GAP exit decision uses pending as registered before that edge (-> IDLE, then HI on the following edge per REQ-013).
REQ-019 The display register SHALL never change outside a load in REQ-012, REQ-013, or REQ-016.
REQ-020 Hex patterns 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-021 segments, dp, and busy SHALL be combinational decodes of registered state; they change on the same edge as the state.
REQ-022 The dwell counter SHALL be sized clog2(MAX_COUNT) bits and SHALL never exceed MAX_COUNT-1.

Reset
REQ-023 rst low SHALL immediately force: state=IDLE, counter=0, display=0x00, pending empty; outputs segments=0x00, dp=0, busy=0, in_ready=1.
REQ-024 Reset asserted mid-display SHALL discard both the displayed and pending values; there is no replay after release.
REQ-025 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-026 The shared package SHALL hold the state enumeration (IDLE, HI, LO, GAP) and the 16-entry hex segment constant table.
REQ-027 The hex-to-seven-segment decode SHALL be a separate combinational sub-module, stackcalc_hex7seg (4-bit in, 7-bit out), instantiated once on the muxed nibble.

Verification (MAX_COUNT=4)
REQ-028 Reset then in_data=0x3A with valid for 1 cycle: 4 cycles segments=0x4F with dp=1, then 4 cycles segments=0x77, then 4 cycles 0x00, then IDLE with busy=0.
REQ-029 During HI of 0x12, present 0x9F: in_ready 1->0 after the handshake; after the 0x12 GAP, 0x6F/dp=1 then 0x71 follow with no IDLE cycle.
REQ-030 Hold valid with a third value while pending is full: in_ready stays 0 and the value is accepted only after pending drains; no data is lost or duplicated.
REQ-031 Handshake in the last GAP cycle with pending empty: exactly one IDLE cycle, then HI of the new value.
REQ-032 Assert rst in LO of 0xC5 with pending 0x44: outputs go to 0x00, dp=0, busy=0, and in_ready=1 asynchronously; after release the block stays in IDLE without showing 0x44.
REQ-033 Sweep all nibbles 0..F through HI and LO and check every pattern against REQ-020.
